// File: rtl/frog_motion_ctrl.sv
// Frog position, lives, score and death/respawn sequencing.
// Ports: i_Clk, i_Rst (async, active high), i_Up/Down/Left/Right buttons,
//   i_Hit collision level, i_Restart; o_Frog_X/Y pixel position,
//   o_Dying, o_Win pulse, o_Game_Over, o_Lives, o_Score.
module frog_motion_ctrl #(
  parameter int GRID         = 32,
  parameter int COLS         = 20,
  parameter int ROWS         = 15,
  parameter int START_COL    = 10,
  parameter int START_ROW    = 14,
  parameter int LIVES        = 3,
  parameter int DEATH_CYCLES = 1000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Left,
  input  logic       i_Right,
  input  logic       i_Hit,
  input  logic       i_Restart,
  output logic [9:0] o_Frog_X,
  output logic [9:0] o_Frog_Y,
  output logic       o_Dying,
  output logic       o_Win,
  output logic       o_Game_Over,
  output logic [2:0] o_Lives,
  output logic [7:0] o_Score
);

  typedef enum logic [1:0] {
    ALIVE,
    DYING,
    GAME_OVER
  } state_t;

  localparam logic [9:0]  X0      = 10'(START_COL * GRID);
  localparam logic [9:0]  Y0      = 10'(START_ROW * GRID);
  localparam logic [9:0]  GR      = 10'(GRID);
  localparam logic [4:0]  C0      = 5'(START_COL);
  localparam logic [3:0]  R0      = 4'(START_ROW);
  localparam logic [4:0]  COL_MAX = 5'(COLS - 1);
  localparam logic [3:0]  ROW_MAX = 4'(ROWS - 1);
  localparam logic [2:0]  LIV     = 3'(LIVES);
  localparam logic [19:0] CNT_END = 20'(DEATH_CYCLES - 1);

  state_t      r_state;
  logic [4:0]  r_col;
  logic [3:0]  r_row;
  logic [9:0]  r_x;
  logic [9:0]  r_y;
  logic [19:0] r_cnt;
  logic [2:0]  r_lives;
  logic [7:0]  r_score;
  logic        r_dying;
  logic        r_win;
  logic        r_go;
  logic        r_up_q;
  logic        r_dn_q;
  logic        r_lt_q;
  logic        r_rt_q;

  logic w_up;
  logic w_dn;
  logic w_lt;
  logic w_rt;

  assign w_up = i_Up & ~r_up_q;
  assign w_dn = i_Down & ~r_dn_q;
  assign w_lt = i_Left & ~r_lt_q;
  assign w_rt = i_Right & ~r_rt_q;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state <= ALIVE;
      r_col   <= C0;
      r_row   <= R0;
      r_x     <= X0;
      r_y     <= Y0;
      r_cnt   <= '0;
      r_lives <= LIV;
      r_score <= '0;
      r_dying <= 1'b0;
      r_win   <= 1'b0;
      r_go    <= 1'b0;
      r_up_q  <= 1'b0;
      r_dn_q  <= 1'b0;
      r_lt_q  <= 1'b0;
      r_rt_q  <= 1'b0;
    end else begin
      // History tracks in every state so a held button never re-fires.
      r_up_q <= i_Up;
      r_dn_q <= i_Down;
      r_lt_q <= i_Left;
      r_rt_q <= i_Right;
      r_win  <= 1'b0;
      case (r_state)
        ALIVE: begin
          if (i_Hit) begin
            r_state <= DYING;
            r_dying <= 1'b1;
            r_lives <= r_lives - 3'd1;
            r_cnt   <= '0;
          end else if (r_row == 4'd0) begin
            // Row 0 is only held for the win-pulse cycle.
            r_col <= C0;
            r_row <= R0;
            r_x   <= X0;
            r_y   <= Y0;
          end else if (w_up) begin
            r_row <= r_row - 4'd1;
            r_y   <= r_y - GR;
            if (r_row == 4'd1) begin
              r_win <= 1'b1;
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            end
          end else if (w_dn) begin
            if (r_row != ROW_MAX) begin
              r_row <= r_row + 4'd1;
              r_y   <= r_y + GR;
            end
          end else if (w_lt) begin
            if (r_col != 5'd0) begin
              r_col <= r_col - 5'd1;
              r_x   <= r_x - GR;
            end
          end else if (w_rt) begin
            if (r_col != COL_MAX) begin
              r_col <= r_col + 5'd1;
              r_x   <= r_x + GR;
            end
          end
        end
        DYING: begin
          if (r_cnt == CNT_END) begin
            r_dying <= 1'b0;
            if (r_lives == 3'd0) begin
              r_state <= GAME_OVER;
              r_go    <= 1'b1;
            end else begin
              r_state <= ALIVE;
              r_col   <= C0;
              r_row   <= R0;
              r_x     <= X0;
              r_y     <= Y0;
            end
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        GAME_OVER: begin
          if (i_Restart) begin
            r_state <= ALIVE;
            r_go    <= 1'b0;
            r_lives <= LIV;
            r_score <= '0;
            r_col   <= C0;
            r_row   <= R0;
            r_x     <= X0;
            r_y     <= Y0;
          end
        end
        default: r_state <= ALIVE;
      endcase
    end
  end

  assign o_Frog_X    = r_x;
  assign o_Frog_Y    = r_y;
  assign o_Dying     = r_dying;
  assign o_Win       = r_win;
  assign o_Game_Over = r_go;
  assign o_Lives     = r_lives;
  assign o_Score     = r_score;

endmodule

// File: doc/frog_motion_ctrl.md
Name: frog_motion_ctrl

Overview:
- Owns the frog's position, lives, score and death/respawn sequencing.
- Consumes debounced direction buttons and the level collision flag from the collision checker.
- Produces the frog pixel coordinates that the collision checker and renderer sample.
- Acts as the producer end of the frog-position/collision loop. It alone moves the frog, freezes it during the explosion and respawns it.

Parameters:
- GRID, 32, pixel size of one grid cell (power of two)
- COLS, 20, playfield width in cells
- ROWS, 15, playfield height in cells
- START_COL, 10, respawn column
- START_ROW, 14, respawn row (bottom)
- LIVES, 3, lives at reset/restart (1..7)
- DEATH_CYCLES, 1000000, clock cycles the frog stays frozen in DYING

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  asynchronous active-high reset
- i_Up / i_Down / i_Left / i_Right  in  1 each  debounced, clock-synchronous button levels
- i_Hit  in  1  collision level from collision checker
- i_Restart  in  1  restart request; honoured only in GAME_OVER
- o_Frog_X  out  10  frog pixel x = col*GRID
- o_Frog_Y  out  10  frog pixel y = row*GRID
- o_Dying  out  1  high throughout DYING (drives explosion sprite)
- o_Win  out  1  one-cycle pulse on reaching row 0
- o_Game_Over  out  1  high in GAME_OVER
- o_Lives  out  3  remaining lives
- o_Score  out  8  crossings completed, saturating at 255

Behaviour:
- Reset, asynchronous and immediate, including mid-DYING:
  - state ALIVE; col=START_COL, row=START_ROW
  - o_Frog_X=START_COL*GRID, o_Frog_Y=START_ROW*GRID
  - o_Lives=LIVES, o_Score=0; o_Dying=0, o_Win=0, o_Game_Over=0
  - death counter 0; button-history registers 0
- Edge detect: each button has a previous-value register. A move request is a 0->1 transition.
  - Holding a button produces exactly one move.
  - Simultaneous edges use priority Up > Down > Left > Right; only one move per cycle.
- Latency: an edge sampled at clock N updates col/row and o_Frog_X/Y at edge N+1. The outputs are registered and glitch-free.
- Moves clamp at the borders, with no wrap:
  - Up at row 0 and Down at row ROWS-1 are ignored.
  - Left at col 0 and Right at col COLS-1 are ignored.
- States:
  - ALIVE: moves accepted. Priority within a cycle is i_Hit, then win check, then move.
  - If i_Hit=1: go to DYING, o_Lives -= 1, counter=0, any same-cycle move discarded. Position holds at the impact cell.
  - Else if a move lands on row 0: o_Win pulses for the cycle after the move. o_Score += 1 (saturates). Next cycle the frog respawns to START. State stays ALIVE.
  - DYING: o_Dying=1. Buttons and i_Hit are ignored, but history registers keep tracking so a button held through death does not trigger a move. Counter increments each cycle.
  - When counter == DYING_CYCLES-1 (DEATH_CYCLES-1): if o_Lives==0 go to GAME_OVER, else respawn to START and go to ALIVE. o_Dying falls on the same edge.
  - GAME_OVER: o_Game_Over=1, position frozen at the death cell, buttons and i_Hit ignored.
  - i_Restart=1 in GAME_OVER: o_Lives=LIVES, o_Score=0, respawn, go to ALIVE. i_Restart is ignored in other states.
- Widths: col 5 bits, row 4 bits. Pixel products are computed into 10 bits; COLS*GRID ≤ 1024 by construction. The death counter is 20 bits; DEATH_CYCLES ≥ 1.
- i_Hit sustained after respawn: if it is still high in the first ALIVE cycle, it causes a new death. This is intended, because the collision checker is level-based.

Test Plan:
- Reset, then pulse i_Right for one cycle -> o_Frog_X 320→352 one cycle after the edge; o_Frog_Y=448; a held button yields no further moves.
- Pulse i_Left 11 times from col 10 -> col reaches 0 after 10 pulses; the 11th pulse leaves o_Frog_X=0.
- 14 Up pulses from row 14 -> at the 14th, o_Frog_Y=0 for one cycle with o_Win=1 and o_Score=1; next cycle o_Frog_Y=448.
- DEATH_CYCLES=8; i_Hit with a same-cycle i_Up edge -> position unchanged, o_Lives 3→2, o_Dying high exactly 8 cycles, then respawn at (320,448); buttons during DYING ignored.
- Three hits with DEATH_CYCLES=4 -> o_Lives=0, o_Game_Over=1 and buttons ignored; i_Restart -> o_Lives=3, o_Score=0, ALIVE at start.
- Assert i_Rst mid-DYING (counter=3) -> all outputs return to reset values immediately; no respawn or life decrement after release.
